// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  localparam int LANE_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // Big-endian lane decode: offset 0 hits the most significant byte.
  function automatic logic [3:0] lane_mask(input logic [1:0] off);
    return 4'b1000 >> off;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-lane write enables and a registered,
// clearable read port that doubles as the response data register.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic          clr,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [3:0][LANE_BITS-1:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q, rdata_d;

  // Contents are never cleared; reset only blocks a coinciding write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int l = 0; l < 4; l++) begin
        if (we[l]) mem[addr][l] <= wdata[l*LANE_BITS +: LANE_BITS];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (clr)     rdata_d = '0;
    else if (re) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage load/store target: one request at a time, fixed latency.
// Optional DMEM_ALIGN_CHECK_EN flags misaligned word accesses via resp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY >= 2) ? LATENCY - 2 : 0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vld_q, vld_d, rdy_q, rdy_d;
  logic          we_q, we_d, byte_q, byte_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;

  logic          commit, rsp_hs, misalign;
  logic          acc_we, acc_byte;
  logic [31:0]   acc_addr, acc_wdata;
  logic [3:0]    mem_we;
  logic          mem_re, rd_clr;
  logic          unused_addr_hi;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vld_d     = vld_q;
    we_d      = we_q;
    byte_d    = byte_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    commit    = 1'b0;
    rsp_hs    = 1'b0;
    acc_we    = we_q;
    acc_byte  = byte_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid && rdy_q) begin
          we_d    = req_we;
          byte_d  = req_byte;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            // Single-cycle latency commits straight from the request bus.
            commit    = 1'b1;
            acc_we    = req_we;
            acc_byte  = req_byte;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            state_d   = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          rsp_hs  = 1'b1;
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) vld_d = 1'b1;
  end

  assign rdy_d = (state_d == IDLE);

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q, err_d;

  assign misalign = !acc_byte && (acc_addr[1:0] != 2'b00);

  always_comb begin
    err_d = err_q;
    if (commit)      err_d = misalign;
    else if (rsp_hs) err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign resp_err = err_q;
`else
  assign misalign = 1'b0;
  assign resp_err = 1'b0;
`endif

  assign mem_re = commit && !acc_we && !misalign;
  assign rd_clr = rsp_hs || (commit && (acc_we || misalign));
  assign mem_we = (commit && acc_we && !misalign)
                ? (acc_byte ? lane_mask(acc_addr[1:0]) : 4'hF) : 4'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    byte_q  <= byte_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .re    (mem_re),
    .clr   (rd_clr),
    .addr  (acc_addr[AW+1:2]),
    .wdata (acc_byte ? {4{acc_wdata[LANE_BITS-1:0]}} : acc_wdata),
    .rdata (resp_rdata)
  );

  assign unused_addr_hi = ^{acc_addr[31:AW+2], addr_q[31:AW+2]};
  assign req_ready      = rdy_q;
  assign resp_valid     = vld_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_byte = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_rdata;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_byte   (req_byte),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  int n_run  = 0;
  int n_fail = 0;
  logic [31:0] model [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: big-endian word memory, byte lane chosen by the low address bits.
  function automatic void model_op(input bit we, input bit byt, input logic [31:0] addr,
                                   input logic [31:0] wdata, output logic [31:0] rd,
                                   output bit err);
    int idx = int'(addr >> 2) % DEPTH;
    int sh  = (3 - int'(addr[1:0])) * 8;
    rd  = '0;
    err = ALIGN && !byt && (addr[1:0] != 2'b00);
    if (err) return;
    if (we) begin
      if (byt) model[idx] = (model[idx] & ~(32'hFF << sh)) | ({24'h0, wdata[7:0]} << sh);
      else     model[idx] = wdata;
    end else begin
      rd = model[idx];
    end
  endfunction

  task automatic xact(input string tag, input bit we, input bit byt, input logic [31:0] addr,
                      input logic [31:0] wdata, input int hold);
    logic [31:0] erd;
    bit          eerr;
    int          n;
    model_op(we, byt, addr, wdata, erd, eerr);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_byte = byt; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_wdata = $urandom;
    n = 1;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    check({tag, " latency"}, 32'(n), 32'(LAT));
    check({tag, " rdata"}, resp_rdata, erd);
    check({tag, " err"}, 32'(resp_err), 32'(eerr));
    for (int i = 0; i < hold; i++) begin
      // A stray store request while the response waits must be ignored.
      req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_addr = addr; req_wdata = $urandom;
      @(negedge clk);
      check({tag, " hold valid"}, 32'(resp_valid), 32'd1);
      check({tag, " hold rdata"}, resp_rdata, erd);
      check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, " post valid"}, 32'(resp_valid), 32'd0);
    check({tag, " post rdata"}, resp_rdata, 32'd0);
    check({tag, " post err"}, 32'(resp_err), 32'd0);
  endtask

  initial begin
    logic [31:0] a, d;
    bit          w, b;
    repeat (3) @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset resp_err", 32'(resp_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post-reset req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 16; i++) xact("init", 1'b1, 1'b0, 32'(i * 4), 32'h0, 0);

    xact("st 10", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    xact("ld 10", 1'b0, 1'b0, 32'h10, 32'h0, 0);
    xact("clr 10", 1'b1, 1'b0, 32'h10, 32'h0, 0);
    xact("stb 11", 1'b1, 1'b1, 32'h11, 32'hFFFFFF55, 0);
    xact("ld 10 hold", 1'b0, 1'b0, 32'h10, 32'h0, 5);
    check("byte lane model", model[4], 32'h00550000);
    xact("st 1004", 1'b1, 1'b0, 32'h1004, 32'hA5A50F0F, 0);
    xact("ld 0004", 1'b0, 1'b0, 32'h0004, 32'h0, 0);

    // Store abandoned by reset while waiting for its commit edge.
    xact("st 20", 1'b1, 1'b0, 32'h20, 32'h12345678, 0);
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("mid-reset req_ready", 32'(req_ready), 32'd0);
    check("mid-reset resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("after reset resp_valid", 32'(resp_valid), 32'd0);
    check("after reset req_ready", 32'(req_ready), 32'd1);
    xact("ld 20 after reset", 1'b0, 1'b0, 32'h20, 32'h0, 0);

`ifdef DMEM_ALIGN_CHECK_EN
    xact("misaligned st 22", 1'b1, 1'b0, 32'h22, 32'hFFFFFFFF, 0);
    xact("ld 20 unchanged", 1'b0, 1'b0, 32'h20, 32'h0, 0);
    xact("ldb 23", 1'b0, 1'b1, 32'h23, 32'h0, 0);
`endif

    for (int i = 0; i < 80; i++) begin
      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)) | (32'($urandom_range(0, 3)) << 12);
      d = $urandom;
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      xact("rand", w, b, a, d, (i % 10 == 0) ? 2 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
